// File: rtl/data_path_elastic.sv
// data_path_elastic: elastic, multi-lane timing-chain data path.
// CHANNELS lanes of WIDTH bits move through DATA_DEPTH register stages; each
// stage applies COMB_DEPTH levels of f(x) = rotl1(x) + 1 per lane unless the
// beat is marked bypass. A valid/ready handshake stalls the whole pipeline as
// one unit (bubbles are held, not collapsed). A synchronous flush drops all
// in-flight beats, and an occupancy counter reports how many are in flight.
module data_path_elastic #(
    parameter  int WIDTH      = 8,
    parameter  int CHANNELS   = 1,
    parameter  int DATA_DEPTH = 10,
    parameter  int COMB_DEPTH = 6,
    localparam int CW         = $clog2(DATA_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,        // asynchronous, active-low
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_data,
    input  logic                         in_bypass,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    out_data,
    output logic [CW-1:0]                count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int LAST = DATA_DEPTH - 1;

    // One level of the lane function: rotate left by one, then add one,
    // dropping the carry out of the lane.
    function automatic logic [WIDTH-1:0] f_level(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] rot;
        rot = {x[WIDTH-2:0], x[WIDTH-1]};
        return rot + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // COMB_DEPTH levels applied to every lane independently; lanes never
    // exchange carries.
    function automatic logic [DW-1:0] f_stage(input logic [DW-1:0] x);
        logic [DW-1:0]    y;
        logic [WIDTH-1:0] lane;
        y = '0;
        for (int l = 0; l < CHANNELS; l++) begin
            lane = x[l*WIDTH +: WIDTH];
            for (int c = 0; c < COMB_DEPTH; c++) begin
                lane = f_level(lane);
            end
            y[l*WIDTH +: WIDTH] = lane;
        end
        return y;
    endfunction

    logic [DW-1:0]         r_data [DATA_DEPTH];
    logic [DATA_DEPTH-1:0] r_valid;
    logic [DATA_DEPTH-1:0] r_bypass;
    logic [CW-1:0]         r_count;

    logic                  w_adv;
    logic                  w_accept;
    logic                  w_out_hs;
    logic [DW-1:0]         w_next [DATA_DEPTH];

    // The last stage's bypass bit has no consumer downstream; it is kept so
    // every stage carries the same fields.
    logic                  w_unused_last_bypass;
    assign w_unused_last_bypass = r_bypass[LAST];

    // Handshake decode: the pipeline advances whenever the output slot is
    // empty or being taken; backpressure reaches in_ready combinationally.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here
        // unconditionally) so no latch can be inferred.
        w_adv    = !r_valid[LAST] || out_ready;
        w_accept = in_valid && w_adv && !flush;
        w_out_hs = r_valid[LAST] && out_ready;
    end

    // Per-stage next data: the stage function, or identity for bypassed beats.
    always_comb begin
        w_next[0] = in_bypass ? in_data : f_stage(in_data);
        for (int k = 1; k < DATA_DEPTH; k++) begin
            w_next[k] = r_bypass[k-1] ? r_data[k-1] : f_stage(r_data[k-1]);
        end
    end

    // Stage registers: shift on advance, load stage 0 only on accept, and
    // clear every valid bit on flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data registers are reset as well because out_data
            // must read 0 during reset, not just out_valid.
            r_valid  <= '0;
            r_bypass <= '0;
            for (int k = 0; k < DATA_DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so each
            // stage samples its predecessor's pre-edge value.
            if (w_adv) begin
                r_valid[0] <= w_accept;
                if (w_accept) begin
                    r_data[0]   <= w_next[0];
                    r_bypass[0] <= in_bypass;
                end
                for (int k = 1; k < DATA_DEPTH; k++) begin
                    r_valid[k]  <= r_valid[k-1];
                    r_bypass[k] <= r_bypass[k-1];
                    r_data[k]   <= w_next[k];
                end
            end
            // Later assignment wins: flush drops every in-flight beat.
            if (flush) begin
                r_valid <= '0;
            end
        end
    end

    // Occupancy: +1 on accept, -1 on output handshake, 0 after flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_accept && !w_out_hs) begin
            r_count <= r_count + CW'(1);
        end else if (!w_accept && w_out_hs) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign in_ready  = w_adv && !flush;
    assign out_valid = r_valid[LAST];
    assign out_data  = r_data[LAST];
    assign count     = r_count;

endmodule

// File: tb/tb_data_path_elastic.sv
// tb_data_path_elastic: directed and randomized bench for data_path_elastic
// (WIDTH=8, CHANNELS=2, DATA_DEPTH=3, COMB_DEPTH=1). A slot-level model holds
// the final expected result of each in-flight beat, computed with plain
// integer arithmetic when the beat enters.
module tb_data_path_elastic;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int D  = 3;
    localparam int C  = 1;
    localparam int DW = CH * W;
    localparam int CW = $clog2(D + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_bypass;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] count;

    data_path_elastic #(
        .WIDTH      (W),
        .CHANNELS   (CH),
        .DATA_DEPTH (D),
        .COMB_DEPTH (C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    // Model: one slot per stage, holding whether a beat is there and the
    // value it will show at the output.
    logic          m_valid [D];
    logic [DW-1:0] m_res   [D];

    // Output handshakes observed (data and cycle) and the last accept cycle.
    logic [DW-1:0] hs_data [$];
    int            hs_cyc  [$];
    int            acc_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected output for a beat: per lane, D*C applications of
    // x -> (2x mod 256 + x div 128 + 1) mod 256, or the input when bypassed.
    function automatic logic [DW-1:0] exp_result(input logic [DW-1:0] d, input logic byp);
        logic [DW-1:0] r;
        int x;
        r = '0;
        if (byp) return d;
        for (int l = 0; l < CH; l++) begin
            x = int'(d[l*W +: W]);
            repeat (D * C) begin
                x = (x * 2) % 256 + x / 128;
                x = (x + 1) % 256;
            end
            r[l*W +: W] = 8'(x);
        end
        return r;
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int k = 0; k < D; k++) if (m_valid[k]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < D; k++) m_valid[k] = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model,
    // advance the model, then move to 1 time unit after the next rising edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic byp,
                        input logic fl, input logic ordy, output logic acc);
        logic exp_adv, exp_ready;
        in_valid  = v;
        in_data   = d;
        in_bypass = byp;
        flush     = fl;
        out_ready = ordy;
        #2;
        exp_adv   = !m_valid[D-1] || ordy;
        exp_ready = exp_adv && !fl;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(m_valid[D-1]));
        if (m_valid[D-1]) check("out_data", 32'(out_data), 32'(m_res[D-1]));
        check("count", 32'(count), 32'(model_count()));
        if (out_valid && ordy) begin
            hs_data.push_back(out_data);
            hs_cyc.push_back(cycle);
        end
        acc = v && exp_ready;
        if (acc) acc_cyc = cycle;
        if (exp_adv) begin
            for (int k = D - 1; k > 0; k--) begin
                m_valid[k] = m_valid[k-1];
                m_res[k]   = m_res[k-1];
            end
            m_valid[0] = acc;
            m_res[0]   = exp_result(d, byp);
        end
        if (fl) model_clear();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
    endtask

    initial begin
        logic          a;
        logic [DW-1:0] beats [5];
        logic [DW-1:0] held;
        int            idx;
        int            t0;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_bypass = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        model_clear();
        for (int k = 0; k < D; k++) m_res[k] = '0;
        acc_cyc = 0;

        // Reset state.
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #11 rst = 1'b1;
        @(posedge clk); #1;

        // Single beat 0x01 in lane 0: out 0x0F three cycles after accept.
        hs_data.delete(); hs_cyc.delete();
        step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, a);
        idle(5);
        check("single_n", 32'(hs_data.size()), 32'd1);
        if (hs_data.size() == 1) begin
            check("single_data", 32'(hs_data[0]), 32'h070F);
            check("single_lat", 32'(hs_cyc[0] - acc_cyc), 32'd3);
        end

        // Back-to-back 0x80, 0xFF: outputs 0x0B, 0x03 on consecutive cycles.
        hs_data.delete(); hs_cyc.delete();
        step(1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, a);
        idle(5);
        check("b2b_n", 32'(hs_data.size()), 32'd2);
        if (hs_data.size() == 2) begin
            check("b2b_data0", 32'(hs_data[0]), 32'h070B);
            check("b2b_data1", 32'(hs_data[1]), 32'h0703);
            check("b2b_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
        end

        // Bypass interleaved with a normal beat; lanes independent (0x80_01).
        hs_data.delete(); hs_cyc.delete();
        step(1'b1, 16'h005A, 1'b1, 1'b0, 1'b1, a);
        step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 16'h8001, 1'b0, 1'b0, 1'b1, a);
        idle(5);
        check("byp_n", 32'(hs_data.size()), 32'd3);
        if (hs_data.size() == 3) begin
            check("byp_data", 32'(hs_data[0]), 32'h005A);
            check("byp_after", 32'(hs_data[1]), 32'h070F);
            check("lanes_data", 32'(hs_data[2]), 32'h0B0F);
        end

        // Backpressure: 5 beats, stall once out_valid rises, then release.
        hs_data.delete(); hs_cyc.delete();
        for (int i = 0; i < 5; i++) beats[i] = 16'h1110 + 16'(i * 16'h0101);
        idx = 0;
        t0 = cycle;
        held = '0;
        for (int c = 0; c < 20; c++) begin
            logic ordy;
            ordy = !(c >= 3 && c < 7);
            if (c == 4) begin
                held = out_data;
                check("stall_count", 32'(count), 32'd3);
                check("stall_in_ready", 32'(in_ready), 32'd0);
            end
            if (c == 6) check("stall_stable", 32'(out_data), 32'(held));
            step(idx < 5, (idx < 5) ? beats[idx] : '0, 1'b0, 1'b0, ordy, a);
            if (a) idx++;
        end
        check("bp_n", 32'(hs_data.size()), 32'd5);
        for (int i = 0; i < 5 && i < hs_data.size(); i++)
            check("bp_order", 32'(hs_data[i]), 32'(exp_result(beats[i], 1'b0)));
        check("bp_cycles", 32'(cycle - t0), 32'd20);

        // Flush with a concurrent input beat while stalled at count=3.
        hs_data.delete(); hs_cyc.delete();
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h2100 + i), 1'b0, 1'b0, 1'b1, a);
        check("fill_count", 32'(count), 32'd3);
        step(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, a);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_count", 32'(count), 32'd0);
        idle(5);
        check("flush_drop", 32'(hs_data.size()), 32'd0);

        // Asynchronous reset mid-stream, then resume.
        hs_data.delete(); hs_cyc.delete();
        step(1'b1, 16'h4401, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 16'h4402, 1'b0, 1'b0, 1'b1, a);
        step(1'b1, 16'h4403, 1'b0, 1'b0, 1'b1, a);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        model_clear();
        for (int k = 0; k < D; k++) m_res[k] = '0;
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #1; cycle += 2;
        hs_data.delete(); hs_cyc.delete();
        step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, a);
        idle(4);
        check("resume_n", 32'(hs_data.size()), 32'd1);
        if (hs_data.size() == 1) check("resume_data", 32'(hs_data[0]), 32'h070F);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), ($urandom % 4) == 0,
                 ($urandom % 20) == 0, ($urandom % 4) != 0, a);
        end
        idle(6);
        check("drain_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
